// File: rtl/odu_pkg.sv
// rtl/odu_pkg.sv - shared types and constants for the ODU error-injection sequencer
//
// Purpose: FSM state encoding, err_mask bit positions and mode encodings used by
//          odu_err_inject_ctrl and its frame counters.
// Ports:   none (package).
package odu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    INJECT = 2'd2,
    GAP    = 2'd3
  } state_e;

  // Bit positions inside err_mask.
  localparam int ERR_DATA  = 0;
  localparam int ERR_VALID = 1;
  localparam int ERR_FS    = 2;
  localparam int ERR_RS    = 3;
  localparam int ERR_MFAS  = 4;

  localparam logic MODE_SINGLE   = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/odu_frame_counter.sv
// rtl/odu_frame_counter.sv - clearable frame counter with terminal-count flag
//
// Purpose: counts frame_start pulses while enabled; tc_o flags that the count
//          currently equals last_i, so the owner can act on the FS that lands
//          on the terminal value.
// Ports:
//   clk_i   system clock
//   rst_i   synchronous active-high reset
//   clr_i   return the count to zero (wins over adv_i)
//   adv_i   advance by one (a qualified frame_start)
//   last_i  terminal value to compare against
//   tc_o    count == last_i
module odu_frame_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             adv_i,
  input  logic [CNT_W-1:0] last_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (adv_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == last_i);

endmodule

// File: rtl/odu_err_inject_ctrl.sv
// rtl/odu_err_inject_ctrl.sv - frame-aligned error-injection sequencer for the ODU test loop
//
// Purpose: opens an injection window aligned to generator frame starts, either
//          once for N frames (SINGLE) or repeatedly N on / M off (PERIODIC),
//          and gates the window with a latched error mask.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i, stop_i         begin a sequence (IDLE only) / abort to IDLE
//   mode_i                  0 SINGLE, 1 PERIODIC
//   err_mask_i              {mfas, rs, fs, valid, data} enables
//   burst_len_i, gap_len_i  frames on / frames off
//   frame_start_i           generator FS pulse, one cycle per frame
//   gen_error_*_o           per-error corruption controls
//   busy_o, done_o          status; done pulses when a SINGLE burst ends
//   burst_count_o           completed bursts since reset, saturating
module odu_err_inject_ctrl
  import odu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             mode_i,
  input  logic [4:0]       err_mask_i,
  input  logic [CNT_W-1:0] burst_len_i,
  input  logic [CNT_W-1:0] gap_len_i,
  input  logic             frame_start_i,
  output logic             gen_error_data_o,
  output logic             gen_error_valid_o,
  output logic             gen_error_fs_o,
  output logic             gen_error_rs_o,
  output logic             gen_error_mfas_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] burst_count_o
);

  state_e           state_q, state_d;
  logic             window_q;
  logic             done_q;
  logic [CNT_W-1:0] burst_count_q;
  logic             mode_q;
  logic [4:0]       mask_q;
  logic [CNT_W-1:0] burst_len_q;
  logic [CNT_W-1:0] gap_len_q;

  logic cfg_load;
  logic burst_close;
  logic burst_tc;
  logic gap_tc;

  // Both counters start at 0 on entry, so the len-th FS is the one seen at len-1.
  odu_frame_counter #(.CNT_W(CNT_W)) u_burst_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  ((state_q != INJECT) || burst_close),
    .adv_i  (frame_start_i && (state_q == INJECT)),
    .last_i (burst_len_q - 1'b1),
    .tc_o   (burst_tc)
  );

  odu_frame_counter #(.CNT_W(CNT_W)) u_gap_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (state_q != GAP),
    .adv_i  (frame_start_i && (state_q == GAP)),
    .last_i (gap_len_q - 1'b1),
    .tc_o   (gap_tc)
  );

  always_comb begin
    state_d     = state_q;
    cfg_load    = 1'b0;
    burst_close = 1'b0;
    case (state_q)
      IDLE: begin
        // A coincident FS is deliberately not a trigger: ARM waits for the next one.
        if (start_i) begin
          state_d  = ARM;
          cfg_load = 1'b1;
        end
      end
      ARM: begin
        if (frame_start_i) state_d = INJECT;
      end
      INJECT: begin
        if (frame_start_i && burst_tc) begin
          burst_close = 1'b1;
          if (mode_q == MODE_PERIODIC) begin
            if (gap_len_q != '0) state_d = GAP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (frame_start_i && gap_tc) state_d = INJECT;
      end
      default: state_d = IDLE;
    endcase
    if (stop_i) begin
      state_d     = IDLE;
      cfg_load    = 1'b0;
      burst_close = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      window_q      <= 1'b0;
      done_q        <= 1'b0;
      burst_count_q <= '0;
      mode_q        <= 1'b0;
      mask_q        <= '0;
      burst_len_q   <= '0;
      gap_len_q     <= '0;
    end else begin
      state_q  <= state_d;
      // The window is exactly "next state is INJECT"; the closing FS stays inside.
      window_q <= (state_d == INJECT);
      done_q   <= burst_close && (mode_q == MODE_SINGLE);
      if (burst_close && (burst_count_q != '1)) begin
        burst_count_q <= burst_count_q + 1'b1;
      end
      if (cfg_load) begin
        mode_q      <= mode_i;
        mask_q      <= err_mask_i;
        burst_len_q <= (burst_len_i == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : burst_len_i;
        gap_len_q   <= gap_len_i;
      end
    end
  end

  assign gen_error_data_o  = window_q & mask_q[ERR_DATA];
  assign gen_error_valid_o = window_q & mask_q[ERR_VALID];
  assign gen_error_fs_o    = window_q & mask_q[ERR_FS];
  assign gen_error_rs_o    = window_q & mask_q[ERR_RS];
  assign gen_error_mfas_o  = window_q & mask_q[ERR_MFAS];
  assign busy_o            = (state_q != IDLE);
  assign done_o            = done_q;
  assign burst_count_o     = burst_count_q;

endmodule

// File: tb/tb_odu_err_inject_ctrl.sv
// tb/tb_odu_err_inject_ctrl.sv - scoreboard bench for odu_err_inject_ctrl
module tb_odu_err_inject_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        mode = 1'b0;
  logic [4:0]  mask = '0;
  logic [15:0] blen = '0;
  logic [15:0] glen = '0;
  logic        fs = 1'b0;
  logic        e_data, e_valid, e_fs, e_rs, e_mfas;
  logic        busy, done;
  logic [15:0] bcnt;

  always #5 clk = ~clk;

  odu_err_inject_ctrl #(.CNT_W(16)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .start_i           (start),
    .stop_i            (stop),
    .mode_i            (mode),
    .err_mask_i        (mask),
    .burst_len_i       (blen),
    .gap_len_i         (glen),
    .frame_start_i     (fs),
    .gen_error_data_o  (e_data),
    .gen_error_valid_o (e_valid),
    .gen_error_fs_o    (e_fs),
    .gen_error_rs_o    (e_rs),
    .gen_error_mfas_o  (e_mfas),
    .busy_o            (busy),
    .done_o            (done),
    .burst_count_o     (bcnt)
  );

  typedef struct {
    int          cyc;
    logic [4:0]  err;
    logic        busy;
    logic        done;
    logic [15:0] bc;
  } exp_t;

  exp_t cq[$];
  int   cyc = 0;
  int   base = 0;
  int   total = 0;
  int   bad = 0;

  // Per-case stimulus times (relative) and hand-computed expectations.
  int st1, st2, sp, ra, rb;
  int e_busy_lo, e_busy_hi, e_done, e_rst;
  logic [4:0] e_mask;
  int wlo[$], whi[$], bct[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, c, act, req);
    end
  endtask

  // Monitor: pops the expectation for the current cycle and compares.
  exp_t mon_e;
  always @(negedge clk) begin
    while (cq.size() > 0 && cq[0].cyc < cyc) begin
      mon_e = cq.pop_front();
      total++;
      bad++;
      $display("FAIL missed_check cyc=%0d got=none want=checked", mon_e.cyc);
    end
    if (cq.size() > 0 && cq[0].cyc == cyc) begin
      mon_e = cq.pop_front();
      chk("gen_error", mon_e.cyc - base, {27'd0, e_mfas, e_rs, e_fs, e_valid, e_data}, {27'd0, mon_e.err});
      chk("busy", mon_e.cyc - base, {31'd0, busy}, {31'd0, mon_e.busy});
      chk("done", mon_e.cyc - base, {31'd0, done}, {31'd0, mon_e.done});
      chk("burst_count", mon_e.cyc - base, {16'd0, bcnt}, {16'd0, mon_e.bc});
    end
  end

  task automatic drive(input int t);
    rst   = (t < 2) || (t >= ra && t < rb);
    start = (t == st1) || (t == st2);
    stop  = (t == sp);
    fs    = (t >= 10) && (((t - 10) % 20) == 0);
    if (t == st2) begin
      // Start while busy plus config churn: both must be ignored.
      mask = 5'b11111;
      blen = 16'd1;
      mode = ~mode;
    end
  endtask

  task automatic push_exp(input int len);
    exp_t e;
    for (int t = 2; t <= len; t++) begin
      e.cyc  = base + t;
      e.err  = '0;
      for (int i = 0; i < wlo.size(); i++)
        if (t >= wlo[i] && t <= whi[i]) e.err = e_mask;
      e.busy = (t >= e_busy_lo) && (t <= e_busy_hi);
      e.done = (t == e_done);
      e.bc   = '0;
      for (int i = 0; i < bct.size(); i++)
        if (t >= bct[i]) e.bc = e.bc + 16'd1;
      if (t >= e_rst) e.bc = '0;
      cq.push_back(e);
    end
  endtask

  task automatic run_case(input int len);
    @(negedge clk);
    base = cyc;
    drive(0);
    push_exp(len);
    for (int t = 1; t <= len; t++) begin
      @(negedge clk);
      drive(t);
    end
  endtask

  task automatic setup(input logic m, input logic [4:0] mk, input int bl, input int gl,
                       input int s1, input int s2, input int spt);
    mode = m; mask = mk; blen = 16'(bl); glen = 16'(gl);
    st1 = s1; st2 = s2; sp = spt; ra = -1; rb = -1;
    e_mask = mk; e_done = -1; e_rst = 1 << 30;
  endtask

  initial begin
    repeat (3) @(negedge clk);

    // SINGLE, burst 2, data; a second start at 20 with new config is ignored.
    setup(1'b0, 5'b00001, 2, 0, 5, 20, -1);
    wlo = {11}; whi = {50}; bct = {51};
    e_busy_lo = 6; e_busy_hi = 50; e_done = 51;
    run_case(70);

    // PERIODIC, burst 1, gap 2, fs; stop at 165.
    setup(1'b1, 5'b00100, 1, 2, 5, -1, 165);
    wlo = {11, 71, 131}; whi = {30, 90, 150}; bct = {31, 91, 151};
    e_busy_lo = 6; e_busy_hi = 165;
    run_case(175);

    // PERIODIC back-to-back, burst 3.
    setup(1'b1, 5'b10010, 3, 0, 5, -1, -1);
    wlo = {11}; whi = {200}; bct = {71, 131, 191};
    e_busy_lo = 6; e_busy_hi = 200;
    run_case(200);

    // SINGLE burst 4 aborted by stop at 40.
    setup(1'b0, 5'b01000, 4, 0, 5, -1, 40);
    wlo = {11}; whi = {40}; bct = {};
    e_busy_lo = 6; e_busy_hi = 40;
    run_case(60);

    // start coincident with FS at 10, burst_len 0 acts as 1.
    setup(1'b0, 5'b10000, 0, 0, 10, -1, -1);
    wlo = {31}; whi = {50}; bct = {51};
    e_busy_lo = 11; e_busy_hi = 50; e_done = 51;
    run_case(60);

    // Reference burst_len 1.
    setup(1'b0, 5'b00010, 1, 0, 5, -1, -1);
    wlo = {11}; whi = {30}; bct = {31};
    e_busy_lo = 6; e_busy_hi = 30; e_done = 31;
    run_case(50);

    // Reset held 3 cycles mid-run in PERIODIC back-to-back.
    setup(1'b1, 5'b11111, 1, 0, 5, -1, -1);
    ra = 60; rb = 63;
    wlo = {11}; whi = {60}; bct = {31, 51}; e_rst = 61;
    e_busy_lo = 6; e_busy_hi = 60;
    run_case(80);

    @(negedge clk);
    @(negedge clk);
    while (cq.size() > 0) begin
      mon_e = cq.pop_front();
      total++;
      bad++;
      $display("FAIL unchecked cyc=%0d got=none want=checked", mon_e.cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/odu_err_inject_ctrl.md
Name: odu_err_inject_ctrl

Overview:
- Frame-aligned error-injection sequencer for the ODU test loop.
- Watches the frame_start pulse coming out of the ODU frame generator.
- Drives the five gen_error_* controls that corrupt data, valid, FS, RS and MFAS between the generator and the checker.
- Supports single bursts of N frames, and periodic bursts (N frames on, M frames off) until stopped.
- Outputs busy/done status and a burst counter for software and bench visibility.

Parameters:
- CNT_W, 16, width of the burst_len and gap_len frame counters and of burst_count.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle request to begin a sequence; honoured only in IDLE.
- stop  in  1  one-cycle abort; returns to IDLE from any state.
- mode  in  1  0 = SINGLE (one burst), 1 = PERIODIC (repeat bursts until stop).
- err_mask  in  5  which errors to assert: bit0 data, bit1 valid, bit2 fs, bit3 rs, bit4 mfas.
- burst_len  in  CNT_W  frames per burst; 0 is treated as 1.
- gap_len  in  CNT_W  frames between bursts in PERIODIC mode; 0 means back-to-back.
- frame_start  in  1  generator FS, taken before error insertion; high for exactly one cycle per frame.
- gen_error_data  out  1  corrupt data.
- gen_error_valid  out  1  force valid low.
- gen_error_fs  out  1  invert FS.
- gen_error_rs  out  1  invert RS.
- gen_error_mfas  out  1  force MFAS to 0.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when a SINGLE burst completes.
- burst_count  out  CNT_W  number of completed bursts since reset; saturates at all-ones.

Behaviour:
- Reset: state IDLE; all gen_error_* outputs 0; busy 0; done 0; burst_count 0; internal counters 0; latched config 0.
- Outputs: all registered. Each gen_error_x equals the registered window bit ANDed with the latched err_mask bit.
- Config latch: mode, err_mask, burst_len and gap_len are latched on an accepted start. Later changes are ignored until the next start. start while busy is ignored.
- State IDLE: on start, go to ARM; busy=1 on the next cycle.
- State ARM: wait for frame_start.
  - FS at cycle t: window=1 from t+1; frm_cnt=0; go to INJECT.
  - The triggering FS itself is not corrupted.
- State INJECT: each FS increments frm_cnt.
  - The FS at which frm_cnt reaches burst_len-1 (the burst_len-th FS after the trigger) closes the burst.
  - That closing FS is still inside the window (window is registered). Window drops at the next cycle.
  - On burst close, burst_count increments (saturating) on the next cycle.
  - SINGLE: go to IDLE; done=1 for one cycle; busy=0.
  - PERIODIC, gap_len=0: stay in INJECT; frm_cnt=0; window stays continuously 1; burst_count still increments per burst.
  - PERIODIC, gap_len>0: go to GAP; gap_cnt=0.
- State GAP: window=0. Each FS increments gap_cnt. On the gap_len-th FS, go to INJECT with window=1 from the next cycle and frm_cnt=0.
- Stop: from any state, go to IDLE next cycle. Window, busy and outputs are 0 from the next cycle. No done pulse; burst_count unchanged. stop overrides start and frame_start in the same cycle.
- Simultaneous start and frame_start in IDLE: start is accepted and state goes to ARM. That FS does not trigger; the next FS does.
- Reset mid-burst: same as the reset values; outputs 0 the cycle after rst is sampled high.
- Counter width: frm_cnt and gap_cnt are CNT_W bits and compare against the latched lengths. No wrap is possible, because the count resets on every match.

Decomposition:
- Shared package odu_pkg:
  - state enum {IDLE, ARM, INJECT, GAP};
  - err_mask bit-index constants (ERR_DATA=0, ERR_VALID=1, ERR_FS=2, ERR_RS=3, ERR_MFAS=4);
  - MODE_SINGLE and MODE_PERIODIC constants.
- One natural sub-module, odu_frame_counter:
  - loadable CNT_W counter that advances on frame_start;
  - provides a terminal-count flag;
  - instanced twice, once for the burst and once for the gap.

Test Plan (bench model raises FS every 20 cycles, first FS at cycle 10):
- Reset check: rst high for 3 cycles mid-run -> all outputs 0, burst_count 0, busy 0 from the cycle after rst is sampled.
- SINGLE mode, burst_len=2, mask=5'b00001, start at cycle 5 -> gen_error_data=1 on cycles 11..50 inclusive; done pulse at cycle 51; burst_count=1; other gen_error_* stay 0.
- PERIODIC mode, burst_len=1, gap_len=2, mask=5'b00100 -> gen_error_fs high on cycles 11..30, 71..90, 131..150; burst_count increments at 31, 91, 151; busy stays 1.
- PERIODIC mode, gap_len=0, burst_len=3 -> window continuously high from cycle 11; burst_count increments every 60 cycles.
- Stop at cycle 40 during the SINGLE case (burst_len=4) -> outputs and busy 0 at 41; no done pulse; burst_count unchanged.
- Edge cases:
  - start coincident with FS at cycle 10 -> window opens at 31, not 11;
  - start asserted while busy -> ignored;
  - burst_len=0 -> behaves exactly as burst_len=1.
